pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register with an integrated skid FIFO, the successor to the fixed if/id latch. It sits between any two pipeline stages and carries an opaque payload of DATA_W bits, for example {instAddr, inst}. It honours the central stall vector, inserts bubbles, supports a synchronous flush on branch or exception, and keeps up to DEPTH in-flight items that upstream delivers while downstream is stopped, so no fetched data is lost.

---
 rtl/pipe_stage_buf.sv | 115 +++++++++++
 tb/tb_pipe_stage_buf.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a DEPTH-entry skid FIFO behind it, so items
// accepted while downstream is stopped are kept in order instead of lost.
module pipe_stage_buf #(
  parameter int                 DATA_W     = 64,
  parameter int                 DEPTH      = 2,
  parameter int                 STALL_W    = 6,
  parameter int                 STAGE      = 1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  localparam int                OCC_W      = $clog2(DEPTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshake: an item moves on a rising edge when in_valid & in_ready and
  // the upstream stage is not stalled; in_ready depends on registered state
  // only, so it never combinationally follows stall or flush.

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  skid_cnt_q, skid_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic adv;
  logic acc;
  logic skid_empty;

  assign adv        = !stall[STAGE+1];
  assign in_ready   = skid_cnt_q < FULL_CNT;
  assign acc        = in_valid && in_ready && !stall[STAGE] && !flush;
  assign skid_empty = skid_cnt_q == '0;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occupancy = OCC_W'(skid_cnt_q) + OCC_W'(out_valid_q);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    skid_cnt_d  = skid_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      skid_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_data_d  = BUBBLE_VAL;
    end else if (adv) begin
      if (!skid_empty) begin
        out_data_d  = mem_q[head_q];
        out_valid_d = 1'b1;
        head_d      = ptr_inc(head_q);
        if (acc) begin
          mem_d[tail_q] = in_data;
          tail_d        = ptr_inc(tail_q);
        end else begin
          skid_cnt_d = skid_cnt_q - 1'b1;
        end
      end else if (acc) begin
        // Empty skid: bypass straight into the output register.
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = BUBBLE_VAL;
      end
    end else if (acc) begin
      mem_d[tail_q] = in_data;
      tail_d        = ptr_inc(tail_q);
      skid_cnt_d    = skid_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      skid_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= BUBBLE_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      skid_cnt_q  <= skid_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 instance for the directed
// scenarios, DEPTH=3 instance for the randomly stalled wrap-around stream.
module tb_pipe_stage_buf;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  // DEPTH=3 instance
  logic [5:0]    stall3;
  logic          flush3;
  logic          in_valid3;
  logic [DW-1:0] in_data3;
  logic          in_ready3;
  logic          out_valid3;
  logic [DW-1:0] out_data3;
  logic [2:0]    occupancy3;

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .stall(stall3), .flush(flush3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .occupancy(occupancy3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic up_stall,
                       input logic dn_stall, input logic fl);
    in_valid = v;
    in_data  = d;
    stall    = 6'd0;
    stall[1] = up_stall;
    stall[2] = dn_stall;
    flush    = fl;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d,
                            input logic [1:0] occ, input logic rdy);
    check({tag, "_valid"}, DW'(out_valid), DW'(v));
    check({tag, "_data"}, out_data, d);
    check({tag, "_occ"}, DW'(occupancy), DW'(occ));
    check({tag, "_ready"}, DW'(in_ready), DW'(rdy));
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    stall3 = '0; flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0;

    // reset
    tick(); tick();
    expect_out("reset", 1'b0, 64'h0, 2'd0, 1'b1);
    rst = 1'b1;
    tick();

    // stream 0xA0..0xA4
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'hA0 + i, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("stream", 1'b1, 64'hA0 + i, 2'd1, 1'b1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("stream_drain", 1'b0, 64'h0, 2'd0, 1'b1);

    // downstream stall fills the skid
    drive(1'b1, 64'hB0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("dstall_b0", 1'b1, 64'hB0, 2'd1, 1'b1);
    drive(1'b1, 64'hB1, 1'b0, 1'b1, 1'b0); tick();
    expect_out("dstall_b1", 1'b1, 64'hB0, 2'd2, 1'b1);
    drive(1'b1, 64'hB2, 1'b0, 1'b1, 1'b0); tick();
    expect_out("dstall_b2", 1'b1, 64'hB0, 2'd3, 1'b0);
    drive(1'b1, 64'hB3, 1'b0, 1'b1, 1'b0); tick();
    expect_out("dstall_full", 1'b1, 64'hB0, 2'd3, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("release_b1", 1'b1, 64'hB1, 2'd2, 1'b1);
    tick();
    expect_out("release_b2", 1'b1, 64'hB2, 2'd1, 1'b1);
    tick();
    expect_out("release_empty", 1'b0, 64'h0, 2'd0, 1'b1);

    // bubble insertion: upstream stalled, item held upstream
    drive(1'b1, 64'hE0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("bubble", 1'b0, 64'h0, 2'd0, 1'b1);
    drive(1'b1, 64'hE0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("bubble_resume", 1'b1, 64'hE0, 2'd1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();

    // flush with full buffer and downstream stall
    drive(1'b1, 64'hF0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hF1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 64'hF2, 1'b0, 1'b1, 1'b0); tick();
    expect_out("pre_flush", 1'b1, 64'hF0, 2'd3, 1'b0);
    drive(1'b1, 64'hF3, 1'b0, 1'b1, 1'b1); tick();
    expect_out("flush", 1'b0, 64'h0, 2'd0, 1'b1);
    drive(1'b1, 64'hC0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("post_flush_c0", 1'b1, 64'hC0, 2'd1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("post_flush_empty", 1'b0, 64'h0, 2'd0, 1'b1);

    // asynchronous reset between edges
    drive(1'b1, 64'h90, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h91, 1'b0, 1'b1, 1'b0); tick();
    expect_out("pre_areset", 1'b1, 64'h90, 2'd2, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    expect_out("areset", 1'b0, 64'h0, 2'd0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 64'hD0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("post_areset_d0", 1'b1, 64'hD0, 2'd1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("post_areset_empty", 1'b0, 64'h0, 2'd0, 1'b1);

    // wrap-around on DEPTH=3 with random downstream stall
    begin
      int sent = 0;
      int recv = 0;
      int cycles = 0;
      logic acc, pop;
      while (recv < 20 && cycles < 400) begin
        stall3      = '0;
        stall3[2]   = ($urandom_range(0, 1) == 1);
        in_valid3   = (sent < 20);
        in_data3    = DW'(64'h100 + sent);
        check("wrap_occ", DW'(occupancy3), DW'(exp_q.size()));
        if (exp_q.size() == 4) check("wrap_full_ready", DW'(in_ready3), '0);
        acc = in_valid3 && in_ready3;
        pop = out_valid3 && !stall3[2];
        if (pop) begin
          if (exp_q.size() == 0) check("wrap_underflow", DW'(out_valid3), '0);
          else check("wrap_order", out_data3, exp_q.pop_front());
          recv++;
        end
        tick();
        if (acc) begin
          exp_q.push_back(in_data3);
          sent++;
        end
        cycles++;
      end
      check("wrap_count", DW'(recv), DW'(20));
      in_valid3 = 1'b0;
      stall3    = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
